// File: rtl/booth4_mult_seq_if.sv
// Handshake and operand/result bundle for the sequential radix-4 Booth multiplier.
// The master side issues operands and start; the slave side returns busy/done/S.
interface booth4_mult_seq_if #(
  parameter int size = 8
);
  logic              start;
  logic              signed_mode;
  logic [size-1:0]   A;
  logic [size-1:0]   B;
  logic              busy;
  logic              done;
  logic [2*size-1:0] S;

  modport master (
    output start, signed_mode, A, B,
    input  busy, done, S
  );

  modport slave (
    input  start, signed_mode, A, B,
    output busy, done, S
  );
endinterface

// File: rtl/booth4_mult_seq.sv
// Sequential radix-4 Booth multiplier: retires two multiplier bits per cycle,
// signed or unsigned operands, start/busy/done handshake with a held product.
module booth4_mult_seq #(
  parameter int size = 8
) (
  input  logic             CLOCK,
  input  logic             RESET,
  booth4_mult_seq_if.slave bus
);

  localparam int W  = size + 2;
  localparam int N  = W / 2;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  if (((size % 2) != 0) || (size < 4)) begin : g_bad_size
    $error("booth4_mult_seq: size must be even and >= 4");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [W-1:0]      m_q, m_d;
  logic [W:0]        hi_q, hi_d;
  logic [W-1:0]      lo_q, lo_d;
  logic              x_q, x_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*size-1:0] s_q, s_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [W-1:0]      a_ext_s;
  logic [W-1:0]      b_ext_s;
  logic [W:0]        addend_s;
  logic [W:0]        sum_s;

  // Operand extension to the internal width; two extra bits let the last
  // Booth group see a proper sign (or zero) for both modes.
  always_comb begin
    if (bus.signed_mode) begin
      a_ext_s = {{2{bus.A[size-1]}}, bus.A};
      b_ext_s = {{2{bus.B[size-1]}}, bus.B};
    end else begin
      a_ext_s = {2'b00, bus.A};
      b_ext_s = {2'b00, bus.B};
    end
  end

  // Booth recoding of {LO[1:0], X} and accumulation into HI
  always_comb begin
    case ({lo_q[1:0], x_q})
      3'b001, 3'b010: addend_s = {m_q[W-1], m_q};
      3'b011:         addend_s = {m_q, 1'b0};
      3'b100:         addend_s = -{m_q, 1'b0};
      3'b101, 3'b110: addend_s = -{m_q[W-1], m_q};
      default:        addend_s = {(W+1){1'b0}};
    endcase
    sum_s = hi_q + addend_s;
  end

  // Control FSM next state and datapath next values
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    x_d     = x_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          m_d     = b_ext_s;
          lo_d    = a_ext_s;
          hi_d    = {(W+1){1'b0}};
          x_d     = 1'b0;
          cnt_d   = {CW{1'b0}};
          state_d = ST_CALC;
          busy_d  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CALC: begin
        // Arithmetic shift of {HI, LO, X} by two after the add
        hi_d  = {sum_s[W], sum_s[W], sum_s[W:2]};
        lo_d  = {sum_s[1:0], lo_q[W-1:2]};
        x_d   = lo_q[1];
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          s_d     = {hi_d[size-3:0], lo_d};
        end else begin
          busy_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs
  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      state_q <= ST_IDLE;
      m_q     <= {W{1'b0}};
      hi_q    <= {(W+1){1'b0}};
      lo_q    <= {W{1'b0}};
      x_q     <= 1'b0;
      cnt_q   <= {CW{1'b0}};
      s_q     <= {(2*size){1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      x_q     <= x_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.S    = s_q;

endmodule

// File: tb/tb_booth4_mult_seq.sv
// Bench for booth4_mult_seq at size=8 and size=16: a timing/arithmetic model
// checked every cycle, plus directed cases with hand-computed products.
module tb_booth4_mult_seq;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  booth4_mult_seq_if #(.size(8))  if8 ();
  booth4_mult_seq_if #(.size(16)) if16 ();

  booth4_mult_seq #(.size(8))  dut8  (.CLOCK(clk), .RESET(rst_n), .bus(if8.slave));
  booth4_mult_seq #(.size(16)) dut16 (.CLOCK(clk), .RESET(rst_n), .bus(if16.slave));

  int compared   = 0;
  int mismatched = 0;
  bit chk_en     = 1'b0;

  logic        in_start [2];
  logic        in_sm    [2];
  logic [31:0] in_a     [2];
  logic [31:0] in_b     [2];
  logic [31:0] out_s    [2];
  logic        out_busy [2];
  logic        out_done [2];

  assign in_start[0] = if8.start;
  assign in_sm[0]    = if8.signed_mode;
  assign in_a[0]     = {24'd0, if8.A};
  assign in_b[0]     = {24'd0, if8.B};
  assign out_s[0]    = {16'd0, if8.S};
  assign out_busy[0] = if8.busy;
  assign out_done[0] = if8.done;
  assign in_start[1] = if16.start;
  assign in_sm[1]    = if16.signed_mode;
  assign in_a[1]     = {16'd0, if16.A};
  assign in_b[1]     = {16'd0, if16.B};
  assign out_s[1]    = if16.S;
  assign out_busy[1] = if16.busy;
  assign out_done[1] = if16.done;

  function automatic int szk(int k);
    return (k == 0) ? 8 : 16;
  endfunction

  function automatic int niter(int k);
    return szk(k) / 2 + 1;
  endfunction

  // Product by plain integer arithmetic, truncated to 2*sz bits
  function automatic logic [31:0] ref_prod(int sz, logic sm, logic [31:0] a, logic [31:0] b);
    longint av, bv, p;
    logic [63:0] omask, imask;
    imask = (64'd1 << sz) - 64'd1;
    omask = (64'd1 << (2 * sz)) - 64'd1;
    av = longint'({32'd0, a} & imask);
    bv = longint'({32'd0, b} & imask);
    if (sm && a[sz-1]) av = av - (longint'(1) <<< sz);
    if (sm && b[sz-1]) bv = bv - (longint'(1) <<< sz);
    p = av * bv;
    return 32'(64'(p) & omask);
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Model: an accepted op stays busy for N cycles, then pulses done with the product
  int          rem     [2];
  logic        ex_busy [2];
  logic        ex_done [2];
  logic [31:0] ex_s    [2];
  logic [31:0] pend    [2];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        rem[k]     <= 0;
        ex_busy[k] <= 1'b0;
        ex_done[k] <= 1'b0;
        ex_s[k]    <= 32'd0;
      end else if (rem[k] > 0) begin
        rem[k]     <= rem[k] - 1;
        ex_busy[k] <= (rem[k] != 1);
        ex_done[k] <= (rem[k] == 1);
        if (rem[k] == 1) ex_s[k] <= pend[k];
      end else begin
        ex_done[k] <= 1'b0;
        ex_busy[k] <= 1'b0;
        if (in_start[k]) begin
          pend[k]    <= ref_prod(szk(k), in_sm[k], in_a[k], in_b[k]);
          rem[k]     <= niter(k);
          ex_busy[k] <= 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("cyc_busy%0d", k), {31'd0, out_busy[k]}, {31'd0, ex_busy[k]});
        chk($sformatf("cyc_done%0d", k), {31'd0, out_done[k]}, {31'd0, ex_done[k]});
        chk($sformatf("cyc_S%0d", k), out_s[k], ex_s[k]);
      end
    end
  end

  task automatic set_in(int k, logic st, logic sm, logic [31:0] a, logic [31:0] b);
    if (k == 0) begin
      if8.start = st; if8.signed_mode = sm; if8.A = a[7:0]; if8.B = b[7:0];
    end else begin
      if16.start = st; if16.signed_mode = sm; if16.A = a[15:0]; if16.B = b[15:0];
    end
  endtask

  task automatic set_start(int k, logic st);
    if (k == 0) if8.start = st;
    else        if16.start = st;
  endtask

  // Counts edges until done is seen; optionally drops start or scrambles inputs
  task automatic wait_done(int k, bit drop, bit toggle, output int lat, output int nbusy);
    lat   = 0;
    nbusy = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (out_busy[k]) nbusy++;
      if (out_done[k]) break;
      if (drop && lat == 1) set_start(k, 1'b0);
      if (toggle) set_in(k, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom);
    end
    if (!out_done[k]) begin
      compared++;
      mismatched++;
      $display("FAIL timeout%0d: got no done, expected done within 40 cycles", k);
    end
  endtask

  int lat, nb, nd;

  initial begin
    set_in(0, 1'b0, 1'b0, 32'd0, 32'd0);
    set_in(1, 1'b0, 1'b0, 32'd0, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    chk("rst_S", out_s[0], 32'd0);
    chk("rst_busy", {31'd0, out_busy[0]}, 32'd0);
    chk("rst_done", {31'd0, out_done[0]}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    set_in(0, 1'b1, 1'b1, 32'h80, 32'h80);
    wait_done(0, 1'b1, 1'b0, lat, nb);
    chk("neg128sq_S", out_s[0], 32'h4000);
    chk("neg128sq_lat", 32'(lat), 32'd6);
    chk("neg128sq_busy", 32'(nb), 32'd5);

    set_in(0, 1'b1, 1'b0, 32'hFF, 32'hFF);
    wait_done(0, 1'b1, 1'b0, lat, nb);
    chk("uff_S", out_s[0], 32'hFE01);
    set_in(0, 1'b1, 1'b1, 32'hFF, 32'hFF);
    wait_done(0, 1'b1, 1'b0, lat, nb);
    chk("sff_S", out_s[0], 32'h0001);

    set_in(0, 1'b1, 1'b1, 32'h7F, 32'hFF);
    @(posedge clk);
    @(negedge clk);
    set_in(0, 1'b1, 1'b1, 32'h00, 32'h55);
    wait_done(0, 1'b0, 1'b0, lat, nb);
    chk("b2b1_S", out_s[0], 32'hFF81);
    chk("b2b1_lat", 32'(lat), 32'd5);
    wait_done(0, 1'b1, 1'b0, lat, nb);
    chk("b2b2_S", out_s[0], 32'h0000);
    chk("b2b2_lat", 32'(lat), 32'd6);

    set_in(0, 1'b1, 1'b0, 32'd3, 32'd5);
    wait_done(0, 1'b0, 1'b1, lat, nb);
    set_in(0, 1'b0, 1'b0, 32'd0, 32'd0);
    chk("tog_S", out_s[0], 32'h000F);
    chk("tog_lat", 32'(lat), 32'd6);
    nd = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_done[0]) nd++;
    end
    chk("tog_single_done", 32'(nd), 32'd0);

    set_in(0, 1'b1, 1'b0, 32'h12, 32'h34);
    @(posedge clk);
    @(negedge clk);
    set_start(0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_S", out_s[0], 32'd0);
    chk("abort_busy", {31'd0, out_busy[0]}, 32'd0);
    nd = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_done[0]) nd++;
    end
    chk("abort_no_done", 32'(nd), 32'd0);
    set_in(0, 1'b1, 1'b0, 32'h12, 32'h34);
    wait_done(0, 1'b1, 1'b0, lat, nb);
    chk("fresh_S", out_s[0], 32'h03A8);

    set_in(1, 1'b1, 1'b1, 32'h8000, 32'h8000);
    wait_done(1, 1'b1, 1'b0, lat, nb);
    chk("w16_S", out_s[1], 32'h40000000);
    chk("w16_lat", 32'(lat), 32'd10);
    chk("w16_busy", 32'(nb), 32'd9);

    for (int i = 0; i < 200; i++) begin
      int k;
      logic sm;
      logic [31:0] a, b;
      k  = ((i % 4) == 3) ? 1 : 0;
      sm = 1'($urandom_range(0, 1));
      a  = $urandom;
      b  = $urandom;
      set_in(k, 1'b1, sm, a, b);
      wait_done(k, 1'b1, 1'b0, lat, nb);
      chk($sformatf("rnd%0d_S", i), out_s[k], ref_prod(szk(k), sm, a, b));
      chk($sformatf("rnd%0d_lat", i), 32'(lat), 32'(niter(k) + 1));
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/booth4_mult_seq.md
Name: booth4_mult_seq

Overview:
- Self-contained sequential radix-4 Booth multiplier: datapath, Booth recoder, iteration counter and control FSM in one block.
- Parametrised in operand width.
- Runtime-selectable signed or unsigned operation.
- start/busy/done handshake, for use as a multiply unit behind a processor or DSP controller.
- Retires 2 multiplier bits per cycle.

Parameters:
- size, 8: operand width in bits. Must be even and >= 4; otherwise elaboration error.

Ports:
- CLOCK  in  1  rising-edge clock
- RESET  in  1  synchronous, active-low reset
- start  in  1  request; sampled only in IDLE or DONE
- signed_mode  in  1  1 = two's-complement operands, 0 = unsigned; captured with operands
- A  in  size  multiplier (drives Booth recoding)
- B  in  size  multiplicand
- busy  out  1  high while state is CALC
- done  out  1  one-cycle pulse when S becomes valid
- S  out  2*size  product, held until the next accepted start

Behaviour:
- Reset
  - One clock; reset is synchronous and active-low (RESET low at a rising CLOCK edge).
  - Forces state IDLE, S=0, busy=0, done=0, counter=0.
  - Overrides all other inputs.
- Internal width: W = size+2.
  - Operands are extended to W bits: sign-extended if signed_mode=1, zero-extended otherwise.
  - Iteration count N = W/2 = size/2+1, identical in both modes.
- Registers
  - M: W bits, holds extended B.
  - HI: W+1 bits, accumulator; headroom for ±2M.
  - LO: W bits, holds extended A.
  - X: 1 bit, Booth guard bit.
  - cnt: clog2(N+1) bits.
- FSM states: IDLE, CALC, DONE.
- IDLE, start=1
  - Capture M and LO; clear HI and X; cnt=0.
  - Next state CALC; S unchanged.
- CALC, one iteration per cycle:
  - Recode {LO[1],LO[0],X}:
    - 000, 111 -> 0
    - 001, 010 -> +M
    - 011 -> +2M
    - 100 -> -2M
    - 101, 110 -> -M
  - Add the selected value, sign-extended to W+1 bits, to HI.
  - Arithmetic shift {HI, LO, X} right by 2: HI MSB replicated twice.
  - cnt++.
  - After the N-th iteration, next state is DONE.
- Entering DONE
  - S <= {HI,LO}[2*size-1:0], i.e. the low 2*size bits of the combined register.
  - Exact in both modes because the true product fits 2*size bits.
- DONE
  - done=1 for exactly this one cycle.
  - start=1: accepted exactly as in IDLE (back-to-back operation); next state CALC; done still pulses this cycle.
  - start=0: next state IDLE.
- Handshake and timing
  - Latency: with start accepted at edge t, done is high during the cycle after edge t+N, i.e. N+1 cycles after acceptance.
  - Throughput: one product per N+1 cycles.
  - busy=1 exactly during the N CALC cycles.
  - start, A, B and signed_mode are ignored while busy=1; changing them during CALC must not affect the result.
- S stability
  - S changes only on the edge entering DONE, or on reset.
  - S remains stable in IDLE and through the next CALC.
- RESET asserted mid-CALC aborts the operation: S=0, no done pulse.
- Corner cases:
  - Most-negative signed operands, e.g. -128 * -128 for size=8: exact via the extra iteration.
  - Unsigned all-ones operands: exact via zero-extension.

Test Plan:
- size=8, signed_mode=1, A=0x80, B=0x80 (-128 * -128) -> busy high 5 cycles; done pulse 6 cycles after start edge; S=0x4000.
- size=8, signed_mode=0, A=0xFF, B=0xFF -> S=0xFE01. Repeat with signed_mode=1 -> S=0x0001.
- size=8, signed_mode=1:
  - A=0x7F, B=0xFF -> S=0xFF81.
  - Then start held high in DONE with A=0x00, B=0x55 -> second done exactly 6 cycles later with S=0x0000.
  - No IDLE cycle between the two operations.
- During CALC of 3*5 (size=8, unsigned), toggle A/B/signed_mode and pulse start -> S=0x000F; single done pulse.
- Start 0x12*0x34, assert RESET low at the 3rd CALC cycle for 1 cycle -> S=0, busy=0, no done. A fresh start then yields S=0x03A8.
- size=16, signed_mode=1, A=B=0x8000 -> N=9; done 10 cycles after start; S=0x40000000. Plus 200 random signed/unsigned vectors checked against a reference model.
